// File: rtl/ald_rfft_pkg.sv
// Shared constants and helpers for the real-FFT butterfly stages.
package ald_rfft_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_SHIFT = 16;

    // Returns the product scaled down by the twiddle fraction bits; callers keep the low WIDTH bits,
    // which equals prod[SHIFT+WIDTH-1:SHIFT].
    function automatic logic [63:0] tw_slice(input logic signed [127:0] prod,
                                             input int unsigned         shift);
        return 64'(prod >>> shift);
    endfunction

endpackage

// File: rtl/ipe_tw_mul.sv
// Registered twiddle multiply for one difference branch, with per-beat bypass.
module ipe_tw_mul
    import ald_rfft_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned SHIFT = DEF_SHIFT
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             en,
    input  logic             bypass_n,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] tf,
    output logic [WIDTH-1:0] dout
);

    logic signed [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]          t_d, t_q;

    always_comb begin
        prod = $signed(din) * $signed(tf);
        t_d  = t_q;
        if (en) begin
            t_d = bypass_n ? WIDTH'(tw_slice(128'(prod), SHIFT)) : din;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            t_q <= '0;
        end else begin
            t_q <= t_d;
        end
    end

    assign dout = t_q;

endmodule

// File: rtl/ipe_stage.sv
// Inverse radix-2 DIT butterfly stage: twiddle on difference branches, then sum/difference,
// with a stalling valid/ready pipeline and a twiddle ROM address counter.
module ipe_stage
    import ald_rfft_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned SHIFT  = DEF_SHIFT,
    parameter int unsigned NUM_TF = 8,
    parameter int unsigned SCALE  = 0,
    localparam int unsigned AW    = (NUM_TF > 1) ? $clog2(NUM_TF) : 1
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             frame_start,
    output logic [AW-1:0]    tf_addr,
    input  logic [WIDTH-1:0] tf,
    input  logic             bypass_n,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last
);

    logic                  adv, accept, at_end;
    logic [AW-1:0]         eff_addr, addr_d, addr_q;

    logic [3:0][WIDTH-1:0] s1_in_d, s1_in_q;
    logic [WIDTH-1:0]      s1_tf_d, s1_tf_q;
    logic                  s1_byp_n_d, s1_byp_n_q;
    logic                  s1_last_d, s1_last_q;
    logic                  s1_vld_d, s1_vld_q;

    logic [WIDTH-1:0]      s2_in0_d, s2_in0_q, s2_in1_d, s2_in1_q;
    logic                  s2_last_d, s2_last_q;
    logic                  s2_vld_d, s2_vld_q;
    logic [WIDTH-1:0]      t2, t3;

    logic [3:0][WIDTH-1:0] out_d, out_q;
    logic                  out_last_d, out_last_q;
    logic                  out_vld_d, out_vld_q;

    // Sum/difference at WIDTH+1 bits; SCALE keeps the top WIDTH bits (arithmetic >>1).
    function automatic logic [WIDTH-1:0] bfly_out(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic             sub);
        logic signed [WIDTH:0] s;
        if (sub) s = $signed({a[WIDTH-1], a}) - $signed({b[WIDTH-1], b});
        else     s = $signed({a[WIDTH-1], a}) + $signed({b[WIDTH-1], b});
        return (SCALE != 0) ? s[WIDTH:1] : s[WIDTH-1:0];
    endfunction

    ipe_tw_mul #(.WIDTH(WIDTH), .SHIFT(SHIFT)) u_mul2 (
        .Clk(Clk), .Reset_n(Reset_n), .en(adv), .bypass_n(s1_byp_n_q),
        .din(s1_in_q[2]), .tf(s1_tf_q), .dout(t2)
    );

    ipe_tw_mul #(.WIDTH(WIDTH), .SHIFT(SHIFT)) u_mul3 (
        .Clk(Clk), .Reset_n(Reset_n), .en(adv), .bypass_n(s1_byp_n_q),
        .din(s1_in_q[3]), .tf(s1_tf_q), .dout(t3)
    );

    always_comb begin
        adv      = !out_vld_q || out_ready;
        accept   = in_valid && adv;
        eff_addr = frame_start ? '0 : addr_q;
        at_end   = (eff_addr == AW'(NUM_TF - 1));

        // Bypassed beats leave the counter alone unless they start a frame.
        addr_d = addr_q;
        if (accept) begin
            if (bypass_n)         addr_d = at_end ? '0 : eff_addr + AW'(1);
            else if (frame_start) addr_d = '0;
        end

        s1_in_d    = s1_in_q;
        s1_tf_d    = s1_tf_q;
        s1_byp_n_d = s1_byp_n_q;
        s1_last_d  = s1_last_q;
        s1_vld_d   = s1_vld_q;
        s2_in0_d   = s2_in0_q;
        s2_in1_d   = s2_in1_q;
        s2_last_d  = s2_last_q;
        s2_vld_d   = s2_vld_q;
        out_d      = out_q;
        out_last_d = out_last_q;
        out_vld_d  = out_vld_q;

        if (adv) begin
            s1_in_d    = {in3, in2, in1, in0};
            s1_tf_d    = tf;
            s1_byp_n_d = bypass_n;
            s1_last_d  = bypass_n && at_end;
            s1_vld_d   = in_valid;

            s2_in0_d   = s1_in_q[0];
            s2_in1_d   = s1_in_q[1];
            s2_last_d  = s1_last_q;
            s2_vld_d   = s1_vld_q;

            out_d[0]   = bfly_out(s2_in0_q, t2, 1'b0);
            out_d[1]   = bfly_out(s2_in0_q, t2, 1'b1);
            out_d[2]   = bfly_out(s2_in1_q, t3, 1'b0);
            out_d[3]   = bfly_out(s2_in1_q, t3, 1'b1);
            out_last_d = s2_last_q;
            out_vld_d  = s2_vld_q;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            addr_q     <= '0;
            s1_in_q    <= '0;
            s1_tf_q    <= '0;
            s1_byp_n_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_vld_q   <= 1'b0;
            s2_in0_q   <= '0;
            s2_in1_q   <= '0;
            s2_last_q  <= 1'b0;
            s2_vld_q   <= 1'b0;
            out_q      <= '0;
            out_last_q <= 1'b0;
            out_vld_q  <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            s1_in_q    <= s1_in_d;
            s1_tf_q    <= s1_tf_d;
            s1_byp_n_q <= s1_byp_n_d;
            s1_last_q  <= s1_last_d;
            s1_vld_q   <= s1_vld_d;
            s2_in0_q   <= s2_in0_d;
            s2_in1_q   <= s2_in1_d;
            s2_last_q  <= s2_last_d;
            s2_vld_q   <= s2_vld_d;
            out_q      <= out_d;
            out_last_q <= out_last_d;
            out_vld_q  <= out_vld_d;
        end
    end

    assign in_ready  = adv;
    assign tf_addr   = addr_q;
    assign out0      = out_q[0];
    assign out1      = out_q[1];
    assign out2      = out_q[2];
    assign out3      = out_q[3];
    assign out_valid = out_vld_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_ipe_stage.sv
// Randomised and directed bench for ipe_stage against a queue-based reference model.
module tb_ipe_stage;

    localparam int NTF = 4;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [31:0] in0, in1, in2, in3, tf;
    logic        in_valid, frame_start, bypass_n, out_ready;
    logic        in_ready, out_valid, out_last;
    logic [1:0]  tf_addr;
    logic [31:0] out0, out1, out2, out3;
    logic        s_in_ready, s_out_valid, s_out_last;
    logic [1:0]  s_tf_addr;
    logic [31:0] s_out0, s_out1, s_out2, s_out3;

    ipe_stage #(.WIDTH(32), .SHIFT(16), .NUM_TF(NTF), .SCALE(0)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .in_valid(in_valid), .in_ready(in_ready), .frame_start(frame_start),
        .tf_addr(tf_addr), .tf(tf), .bypass_n(bypass_n),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
    );

    ipe_stage #(.WIDTH(32), .SHIFT(16), .NUM_TF(NTF), .SCALE(1)) dut_s (
        .Clk(Clk), .Reset_n(Reset_n), .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .in_valid(in_valid), .in_ready(s_in_ready), .frame_start(frame_start),
        .tf_addr(s_tf_addr), .tf(tf), .bypass_n(bypass_n),
        .out0(s_out0), .out1(s_out1), .out2(s_out2), .out3(s_out3),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_last(s_out_last)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [3:0][31:0] o;
        logic [3:0][31:0] s;
        logic             last;
    } exp_t;

    exp_t        q[$];
    exp_t        e_pop, e_push;
    int          exp_addr = 0;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_out    = 0;
    int          n_last   = 0;
    logic        hold_pend = 1'b0;
    logic [63:0] held01, held23;
    logic        held_last;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] tw(input logic [31:0] d, input logic [31:0] t, input logic bn);
        longint p;
        if (!bn) return d;
        p = longint'($signed(d)) * longint'($signed(t));
        p = p / 65536 - ((p % 65536 != 0 && p < 0) ? 1 : 0);  // floor division by 1.0
        return p[31:0];
    endfunction

    function automatic logic [31:0] bf(input logic [31:0] a, input logic [31:0] b,
                                       input bit sub, input bit scale);
        longint s;
        s = sub ? longint'($signed(a)) - longint'($signed(b))
                : longint'($signed(a)) + longint'($signed(b));
        if (scale) s = s >>> 1;
        return s[31:0];
    endfunction

    always @(negedge Clk) begin
        if (!Reset_n) begin
            q.delete();
            exp_addr  = 0;
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_out01", {out0, out1}, held01);
                chk("hold_out23", {out2, out3}, held23);
                chk("hold_last", out_last, held_last);
            end
            chk("in_ready", in_ready, !out_valid || out_ready);
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("spurious_out", out_valid, 0);
                else begin
                    e_pop = q.pop_front();
                    chk("out0", out0, e_pop.o[0]);
                    chk("out1", out1, e_pop.o[1]);
                    chk("out2", out2, e_pop.o[2]);
                    chk("out3", out3, e_pop.o[3]);
                    chk("out_last", out_last, e_pop.last);
                    chk("s_valid", s_out_valid, 1);
                    chk("s_out01", {s_out0, s_out1}, {e_pop.s[0], e_pop.s[1]});
                    chk("s_out23", {s_out2, s_out3}, {e_pop.s[2], e_pop.s[3]});
                    chk("s_last", s_out_last, e_pop.last);
                    n_out++;
                    if (out_last) n_last++;
                end
            end
            hold_pend = out_valid && !out_ready;
            held01    = {out0, out1};
            held23    = {out2, out3};
            held_last = out_last;
            if (in_valid && in_ready) begin
                int          eff;
                logic [31:0] t2, t3;
                chk("tf_addr", tf_addr, exp_addr);
                chk("s_tf_addr", s_tf_addr, exp_addr);
                chk("s_in_ready", s_in_ready, 1);
                eff = frame_start ? 0 : exp_addr;
                if (bypass_n) begin
                    e_push.last = (eff == NTF - 1);
                    exp_addr    = (eff + 1) % NTF;
                end else begin
                    e_push.last = 1'b0;
                    if (frame_start) exp_addr = 0;
                end
                t2 = tw(in2, tf, bypass_n);
                t3 = tw(in3, tf, bypass_n);
                for (int k = 0; k < 2; k++) begin
                    e_push.o[0] = bf(in0, t2, 0, 0);  e_push.s[0] = bf(in0, t2, 0, 1);
                    e_push.o[1] = bf(in0, t2, 1, 0);  e_push.s[1] = bf(in0, t2, 1, 1);
                    e_push.o[2] = bf(in1, t3, 0, 0);  e_push.s[2] = bf(in1, t3, 0, 1);
                    e_push.o[3] = bf(in1, t3, 1, 0);  e_push.s[3] = bf(in1, t3, 1, 1);
                end
                q.push_back(e_push);
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive_beat(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                              input logic [31:0] d, input logic [31:0] t, input logic bn,
                              input logic fs);
        bit ok = 0;
        in0 = a; in1 = b; in2 = c; in3 = d; tf = t;
        bypass_n = bn; frame_start = fs; in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge Clk);
            if (in_ready) begin ok = 1; break; end
        end
        if (!ok) chk("accept_timeout", in_ready, 1);
        step();
        in_valid = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge Clk);
            if (out_valid) begin n = i; break; end
        end
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (8) @(negedge Clk);
        chk("drain_empty", q.size(), 0);
        step();
    endtask

    initial begin
        int n, n0, l0;
        int addr_tbl[6];
        addr_tbl = '{0, 1, 2, 3, 0, 1};
        Reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; frame_start = 1'b0; bypass_n = 1'b1;
        in0 = '0; in1 = '0; in2 = '0; in3 = '0; tf = '0;
        repeat (3) @(posedge Clk);
        #1 Reset_n = 1'b1;
        @(negedge Clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_addr", tf_addr, 0);
        chk("rst_out", {out0, out1, out2, out3}, 0);

        step();
        drive_beat(5, 7, 3, 2, 32'h0001_0000, 1'b1, 1'b0);
        wait_valid(n);
        chk("basic_latency", n, 3);
        chk("basic_out01", {out0, out1}, {32'd8, 32'd2});
        chk("basic_out23", {out2, out3}, {32'd9, 32'd5});
        @(negedge Clk);
        chk("basic_one_cycle", out_valid, 0);

        step();
        drive_beat(10, 0, 32'hFFFF_FFFC, 0, 32'h0000_8000, 1'b1, 1'b0);
        wait_valid(n);
        chk("frac_out01", {out0, out1}, {32'd8, 32'd12});
        step();
        drive_beat(9, 0, 4, 0, 32'h0001_0000, 1'b1, 1'b0);
        wait_valid(n);
        chk("scale_out01", {s_out0, s_out1}, {32'd6, 32'd2});

        step();
        drive_beat(1, 2, 3, 4, 0, 1'b0, 1'b0);
        wait_valid(n);
        chk("byp_out01", {out0, out1}, {32'd4, 32'hFFFF_FFFE});
        chk("byp_out23", {out2, out3}, {32'd6, 32'hFFFF_FFFE});
        chk("byp_last", out_last, 0);
        chk("byp_addr", tf_addr, 3);

        step();
        out_ready = 1'b0;
        n0 = n_out;
        for (int i = 0; i < 3; i++) drive_beat($urandom, $urandom, $urandom, $urandom, $urandom, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            chk("stall_ready", in_ready, 0);
        end
        step();
        out_ready = 1'b1;
        repeat (6) @(negedge Clk);
        chk("stall_count", n_out - n0, 3);
        step();

        for (int i = 0; i < 400; i++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            out_ready   = ($urandom_range(0, 3) != 0);
            bypass_n    = ($urandom_range(0, 4) != 0);
            frame_start = ($urandom_range(0, 7) == 0);
            in0 = $urandom; in1 = $urandom; in2 = $urandom; in3 = $urandom; tf = $urandom;
            step();
        end
        drain();

        Reset_n = 1'b0;
        step();
        Reset_n = 1'b1;
        l0 = n_last;
        for (int i = 0; i < 6; i++) begin
            in0 = $urandom; in1 = $urandom; in2 = $urandom; in3 = $urandom; tf = $urandom;
            bypass_n = 1'b1; frame_start = (i == 5); in_valid = 1'b1;
            @(negedge Clk);
            chk("wrap_addr", tf_addr, addr_tbl[i]);
            step();
        end
        frame_start = 1'b0;
        drain();
        chk("wrap_last_count", n_last - l0, 1);
        chk("wrap_end_addr", tf_addr, 1);

        drive_beat($urandom, $urandom, $urandom, $urandom, $urandom, 1'b1, 1'b0);
        drive_beat($urandom, $urandom, $urandom, $urandom, $urandom, 1'b1, 1'b0);
        Reset_n = 1'b0;
        step();
        Reset_n = 1'b1;
        @(negedge Clk);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_out", {out0, out1, out2, out3}, 0);
        chk("mid_rst_addr", tf_addr, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_last", out_last, 0);
        repeat (5) @(negedge Clk);
        chk("mid_rst_no_out", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
